// File: rtl/bp_update_ctrl.sv
// Branch-predictor counter update sequencer: queues resolution events and performs a
// two-stage read-modify-write of 2-bit saturating counters with in-flight write forwarding.
module bp_update_ctrl #(
  parameter int PC_WIDTH = 32,
  parameter int DWIDTH   = 2,
  parameter int LINES    = 8,
  parameter int QDEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  output logic                upd_ready,
  input  logic                hold,
  output logic [PC_WIDTH-3:0] cache_ra,
  input  logic [DWIDTH-1:0]   cache_dout,
  input  logic                cache_hit,
  output logic [PC_WIDTH-3:0] cache_wa,
  output logic [DWIDTH-1:0]   cache_din,
  output logic                cache_we,
  output logic                busy
);
  localparam int AWIDTH     = PC_WIDTH - 2;
  localparam int INDEX_BITS = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int PTR_W      = $clog2(QDEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(QDEPTH);
  localparam logic [DWIDTH-1:0] CTR_MAX = '1;
  localparam logic [DWIDTH-1:0] WEAK_T  = DWIDTH'(1) << (DWIDTH - 1);
  localparam logic [DWIDTH-1:0] WEAK_NT = WEAK_T - DWIDTH'(1);

  function automatic logic [DWIDTH-1:0] next_ctr(input logic hit, input logic taken,
                                                 input logic [DWIDTH-1:0] c);
    logic [DWIDTH-1:0] r;
    if (!hit)
      r = taken ? WEAK_T : WEAK_NT;
    else if (taken)
      r = (c == CTR_MAX) ? c : c + DWIDTH'(1);
    else
      r = (c == '0) ? c : c - DWIDTH'(1);
    return r;
  endfunction

  logic [AWIDTH-1:0] r_addr_q  [QDEPTH];
  logic              r_taken_q [QDEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_s2_vld;
  logic [AWIDTH-1:0] r_s2_addr;
  logic [DWIDTH-1:0] r_s2_din;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [AWIDTH-1:0] w_head_addr;
  logic              w_head_taken;
  logic              w_same_idx;
  logic              w_fwd;
  logic              w_hit;
  logic [DWIDTH-1:0] w_cur;
  logic [DWIDTH-1:0] w_new;
  logic              w_unused_pc_lo;

  assign w_unused_pc_lo = ^upd_pc[1:0];

  assign w_empty      = (r_count == '0);
  assign upd_ready    = !reset && (r_count != FULL);
  assign w_push       = upd_valid && upd_ready;
  assign w_pop        = !w_empty && !hold;
  assign w_head_addr  = r_addr_q[r_rptr];
  assign w_head_taken = r_taken_q[r_rptr];
  assign cache_ra     = w_empty ? '0 : w_head_addr;

  // A pending write to the same index replaces the line at the end of this cycle, so it
  // either supplies the counter (same address) or turns the lookup into a miss (alias).
  assign w_same_idx = r_s2_vld && (r_s2_addr[INDEX_BITS-1:0] == w_head_addr[INDEX_BITS-1:0]);
  assign w_fwd      = w_same_idx && (r_s2_addr == w_head_addr);
  assign w_hit      = w_fwd || (!w_same_idx && cache_hit);
  assign w_cur      = w_fwd ? r_s2_din : cache_dout;
  assign w_new      = next_ctr(w_hit, w_head_taken, w_cur);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wptr]  <= upd_pc[PC_WIDTH-1:2];
      r_taken_q[r_wptr] <= upd_taken;
    end
  end

  // S1 -> S2 boundary: head lookup result is registered as the write transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_addr <= '0;
      r_s2_din  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_s2_vld <= w_pop;
      if (w_pop) begin
        r_s2_addr <= w_head_addr;
        r_s2_din  <= w_new;
      end
    end
  end

  assign cache_we  = r_s2_vld;
  assign cache_wa  = r_s2_addr;
  assign cache_din = r_s2_din;
  assign busy      = !w_empty || r_s2_vld;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed scenarios plus randomized traffic against a
// sequential counter-cache reference model and a simple line cache driven by the DUT.
module tb_bp_update_ctrl;
  localparam int PC_WIDTH = 32;
  localparam int DWIDTH   = 2;
  localparam int LINES    = 8;
  localparam int QDEPTH   = 4;
  localparam int AW       = PC_WIDTH - 2;

  logic          clk = 1'b0;
  logic          reset, upd_valid, upd_taken, upd_ready, hold;
  logic [31:0]   upd_pc;
  logic [AW-1:0] cache_ra, cache_wa;
  logic [1:0]    cache_dout, cache_din;
  logic          cache_hit, cache_we, busy;

  int total = 0;
  int bad   = 0;

  logic          env_vld [LINES];
  logic [AW-1:0] env_tag [LINES];
  logic [1:0]    env_cnt [LINES];
  logic          ref_vld [LINES];
  logic [AW-1:0] ref_tag [LINES];
  int            ref_cnt [LINES];

  typedef struct {
    logic [AW-1:0] a;
    logic [1:0]    d;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign cache_hit  = env_vld[cache_ra[2:0]] && (env_tag[cache_ra[2:0]] == cache_ra);
  assign cache_dout = env_cnt[cache_ra[2:0]];

  bp_update_ctrl #(.PC_WIDTH(PC_WIDTH), .DWIDTH(DWIDTH), .LINES(LINES), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .hold(hold), .cache_ra(cache_ra), .cache_dout(cache_dout),
    .cache_hit(cache_hit), .cache_wa(cache_wa), .cache_din(cache_din), .cache_we(cache_we),
    .busy(busy)
  );

  // One clock; the cache commits the write that was presented during the finished cycle.
  task automatic tick();
    logic          we;
    logic [AW-1:0] wa;
    logic [1:0]    din;
    we = cache_we; wa = cache_wa; din = cache_din;
    @(posedge clk);
    #1;
    if (we && !reset) begin
      env_vld[wa[2:0]] = 1'b1;
      env_tag[wa[2:0]] = wa;
      env_cnt[wa[2:0]] = din;
    end
  endtask

  task automatic clear_cache();
    for (int i = 0; i < LINES; i++) begin
      env_vld[i] = 1'b0; env_tag[i] = '0; env_cnt[i] = 2'b00;
      ref_vld[i] = 1'b0; ref_tag[i] = '0; ref_cnt[i] = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", cache_we); end
    total++; if (cache_wa !== '0) begin bad++; $display("FAIL rst_wa got=%h want=0", cache_wa); end
    total++; if (cache_din !== 2'b00) begin bad++; $display("FAIL rst_din got=%b want=00", cache_din); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", upd_ready); end
    reset = 1'b0;
    #1;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rel got=%b want=1", upd_ready); end
  endtask

  task automatic test_basic();
    clear_cache();
    upd_pc = 32'h100; upd_taken = 1'b1; upd_valid = 1'b1;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", upd_ready); end
    tick();
    upd_valid = 1'b0;
    #1;
    total++; if (cache_ra !== 30'h40) begin bad++; $display("FAIL basic_ra got=%h want=40", cache_ra); end
    total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL basic_we_early got=%b want=0", cache_we); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    tick();
    total++; if (cache_we !== 1'b1) begin bad++; $display("FAIL basic_we got=%b want=1", cache_we); end
    total++; if (cache_wa !== 30'h40) begin bad++; $display("FAIL basic_wa got=%h want=40", cache_wa); end
    total++; if (cache_din !== 2'b10) begin bad++; $display("FAIL basic_din got=%b want=10", cache_din); end
    tick();
    total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL basic_we_once got=%b want=0", cache_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy); end
  endtask

  task automatic test_saturation();
    logic [AW-1:0] a_tab [4] = '{30'h40, 30'h41, 30'h42, 30'h43};
    logic          v_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]    c_tab [4] = '{2'b11, 2'b00, 2'b01, 2'b11};
    logic          t_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]    e_tab [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      clear_cache();
      env_vld[a_tab[i][2:0]] = v_tab[i];
      env_tag[a_tab[i][2:0]] = a_tab[i];
      env_cnt[a_tab[i][2:0]] = c_tab[i];
      upd_pc = {a_tab[i], 2'b00}; upd_taken = t_tab[i]; upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      tick();
      total++; if (cache_we !== 1'b1) begin bad++; $display("FAIL sat%0d_we got=%b want=1", i, cache_we); end
      total++;
      if (cache_din !== e_tab[i]) begin
        bad++; $display("FAIL sat%0d_din got=%b want=%b", i, cache_din, e_tab[i]);
      end
      tick();
    end
  endtask

  task automatic test_forward();
    clear_cache();
    upd_pc = 32'h200; upd_taken = 1'b1; upd_valid = 1'b1;
    tick();
    tick();
    upd_valid = 1'b0;
    total++; if (cache_we !== 1'b1) begin bad++; $display("FAIL fwd_we1 got=%b want=1", cache_we); end
    total++; if (cache_wa !== 30'h80) begin bad++; $display("FAIL fwd_wa1 got=%h want=80", cache_wa); end
    total++; if (cache_din !== 2'b10) begin bad++; $display("FAIL fwd_din1 got=%b want=10", cache_din); end
    tick();
    total++; if (cache_we !== 1'b1) begin bad++; $display("FAIL fwd_we2 got=%b want=1", cache_we); end
    total++; if (cache_din !== 2'b11) begin bad++; $display("FAIL fwd_din2 got=%b want=11", cache_din); end
    tick();
    total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL fwd_we3 got=%b want=0", cache_we); end
  endtask

  task automatic test_alias();
    clear_cache();
    env_vld[0] = 1'b1; env_tag[0] = 30'h48; env_cnt[0] = 2'b11;
    upd_pc = 32'h100; upd_taken = 1'b1; upd_valid = 1'b1;
    tick();
    upd_pc = 32'h120;
    tick();
    upd_valid = 1'b0;
    total++; if (cache_wa !== 30'h40) begin bad++; $display("FAIL alias_wa1 got=%h want=40", cache_wa); end
    total++; if (cache_din !== 2'b10) begin bad++; $display("FAIL alias_din1 got=%b want=10", cache_din); end
    tick();
    total++; if (cache_we !== 1'b1) begin bad++; $display("FAIL alias_we2 got=%b want=1", cache_we); end
    total++; if (cache_wa !== 30'h48) begin bad++; $display("FAIL alias_wa2 got=%h want=48", cache_wa); end
    total++; if (cache_din !== 2'b10) begin bad++; $display("FAIL alias_din2 got=%b want=10", cache_din); end
    tick();
  endtask

  task automatic test_hold_full();
    logic [AW-1:0] a;
    clear_cache();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = AW'(32'h50 + i);
      upd_pc = {a, 2'b00}; upd_taken = (i % 2 == 0); upd_valid = 1'b1;
      total++;
      if (upd_ready !== (i < QDEPTH)) begin
        bad++; $display("FAIL full_ready%0d got=%b want=%b", i, upd_ready, (i < QDEPTH));
      end
      tick();
    end
    upd_valid = 1'b0;
    total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL full_held_we got=%b want=0", cache_we); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b want=1", busy); end
    hold = 1'b0;
    tick();
    for (int i = 0; i < QDEPTH; i++) begin
      a = AW'(32'h50 + i);
      total++; if (cache_we !== 1'b1) begin bad++; $display("FAIL drain%0d_we got=%b want=1", i, cache_we); end
      total++; if (cache_wa !== a) begin bad++; $display("FAIL drain%0d_wa got=%h want=%h", i, cache_wa, a); end
      total++;
      if (cache_din !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL drain%0d_din got=%b want=%b", i, cache_din, ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL drain%0d_ready got=%b want=1", i, upd_ready); end
      tick();
    end
    total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL drain_extra got=%b want=0", cache_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_cache();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_pc = 32'h300 + 32'(i * 4); upd_taken = 1'b1; upd_valid = 1'b1;
      tick();
    end
    upd_valid = 1'b0;
    hold = 1'b0;
    tick();
    total++; if (cache_we !== 1'b1) begin bad++; $display("FAIL rmid_pre_we got=%b want=1", cache_we); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", cache_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b want=0", upd_ready); end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL rmid_stale%0d got=%b want=0", i, cache_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy%0d got=%b want=0", i, busy); end
      tick();
    end
  endtask

  task automatic test_random();
    int            occ;
    logic          s2m;
    logic          v, h, t, acc, pop, hit;
    logic [AW-1:0] a;
    int            c, nc;
    exp_t          e;
    clear_cache();
    exp_q.delete();
    occ = 0;
    s2m = 1'b0;
    for (int cyc = 0; cyc < 430; cyc++) begin
      if (cache_we === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_spurious cyc=%0d got wa=%h want no write", cyc, cache_wa);
        end else begin
          e = exp_q.pop_front();
          if (cache_wa !== e.a || cache_din !== e.d) begin
            bad++;
            $display("FAIL rand_write cyc=%0d got wa=%h din=%b want wa=%h din=%b",
                     cyc, cache_wa, cache_din, e.a, e.d);
          end
        end
      end
      total++;
      if (busy !== ((occ != 0) || s2m)) begin
        bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, busy, ((occ != 0) || s2m));
      end
      total++;
      if (upd_ready !== (occ < QDEPTH)) begin
        bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, upd_ready, (occ < QDEPTH));
      end
      if (cyc < 400) begin
        v = ($urandom_range(0, 3) != 0);
        h = ($urandom_range(0, 3) == 0);
      end else begin
        v = 1'b0;
        h = 1'b0;
      end
      a = AW'($urandom_range(0, 15));
      t = 1'($urandom_range(0, 1));
      upd_valid = v; hold = h; upd_taken = t; upd_pc = {a, 2'b00};
      acc = v && (occ < QDEPTH);
      if (acc) begin
        hit = ref_vld[a[2:0]] && (ref_tag[a[2:0]] == a);
        c = ref_cnt[a[2:0]];
        if (!hit)   nc = t ? 2 : 1;
        else if (t) nc = (c + 1 > 3) ? 3 : c + 1;
        else        nc = (c - 1 < 0) ? 0 : c - 1;
        ref_vld[a[2:0]] = 1'b1;
        ref_tag[a[2:0]] = a;
        ref_cnt[a[2:0]] = nc;
        e.a = a;
        e.d = 2'(nc);
        exp_q.push_back(e);
      end
      pop = (occ > 0) && !h;
      occ = occ + (acc ? 1 : 0) - (pop ? 1 : 0);
      s2m = pop;
      tick();
    end
    upd_valid = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d left want=0", exp_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle got=%b want=0", busy); end
  endtask

  initial begin
    reset = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; hold = 1'b0;
    clear_cache();
    test_reset();
    test_basic();
    test_saturation();
    test_forward();
    test_alias();
    test_hold_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
